// File: rtl/ula_mult_div.sv
// ula_mult_div: multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Operands are reduced to magnitudes at start, a radix-2 loop runs for
// WIDTH steps, and the sign is restored in the FIX cycle before HI/LO update.
module ula_mult_div #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       OP,
    input  logic             START,
    input  logic             MTHI,
    input  logic             MTLO,
    output logic             BUSY,
    output logic             READY,
    output logic             DZ,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    localparam int CW = $clog2(WIDTH + 1);
    // The counter reaches WIDTH after the last step; that extra CALC cycle
    // hands over to FIX so results land WIDTH+2 edges after START.
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 is_div_q, is_div_d;
    logic [WIDTH-1:0]     a_q, a_d;        // |multiplicand| or shifting |dividend|
    logic [WIDTH-1:0]     b_q, b_d;        // shifting |multiplier| or |divisor|
    logic [2*WIDTH-1:0]   acc_q, acc_d;    // product, or {remainder, quotient}
    logic                 neg_q, neg_d;    // negate product / quotient
    logic                 rneg_q, rneg_d;  // negate remainder
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 dz_q, dz_d;
    logic                 ready_q, ready_d;

    logic                 sgn;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       rem_try;
    logic                 ge;
    logic [WIDTH-1:0]     rem_new;
    logic [WIDTH-1:0]     q_raw;
    logic [WIDTH-1:0]     r_raw;

    // Next-state, datapath step and HI/LO update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dz_d     = dz_q;
        ready_d  = 1'b0;
        sgn      = ~OP[0];
        sum      = '0;
        rem_try  = '0;
        ge       = 1'b0;
        rem_new  = '0;
        q_raw    = acc_q[WIDTH-1:0];
        r_raw    = acc_q[2*WIDTH-1:WIDTH];

        case (state_q)
            IDLE: begin
                if (START) begin
                    is_div_d = OP[1];
                    a_d      = (sgn && A[WIDTH-1]) ? -A : A;
                    b_d      = (sgn && B[WIDTH-1]) ? -B : B;
                    neg_d    = sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
                    rneg_d   = sgn & A[WIDTH-1];
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = CALC;
                end else begin
                    if (MTHI) hi_d = A;
                    if (MTLO) lo_d = A;
                end
            end
            CALC: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (!is_div_q) begin
                        // shift-add, multiplier bits consumed LSB first
                        sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (b_q[0] ? a_q : '0)};
                        acc_d = {sum, acc_q[WIDTH-1:1]};
                        b_d   = b_q >> 1;
                    end else begin
                        // restoring division, dividend bits consumed MSB first
                        rem_try = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
                        ge      = rem_try >= {1'b0, b_q};
                        rem_new = ge ? (rem_try[WIDTH-1:0] - b_q) : rem_try[WIDTH-1:0];
                        acc_d   = {rem_new, acc_q[WIDTH-2:0], ge};
                        a_d     = a_q << 1;
                    end
                end
            end
            FIX: begin
                if (is_div_q) begin
                    // divisor register is untouched by the divide loop
                    dz_d = (b_q == '0);
                    lo_d = (b_q == '0) ? '1 : (neg_q ? -q_raw : q_raw);
                    hi_d = rneg_q ? -r_raw : r_raw;
                end else begin
                    dz_d = 1'b0;
                    {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
                end
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers; reset drops any operation in flight
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            dz_q     <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dz_q     <= dz_d;
            ready_q  <= ready_d;
        end
    end

    assign BUSY  = (state_q != IDLE);
    assign READY = ready_q;
    assign DZ    = dz_q;
    assign HI    = hi_q;
    assign LO    = lo_q;

endmodule

// File: tb/tb_ula_mult_div.sv
// Bench for ula_mult_div: directed corner cases plus randomized operations,
// checked against a plain-arithmetic reference model.
module tb_ula_mult_div;

    localparam int W = 32;
    localparam int LAT = W + 2;   // READY edge, START edge = 0

    logic         clock = 1'b0;
    logic         reset_n;
    logic [W-1:0] A, B;
    logic [1:0]   OP;
    logic         START, MTHI, MTLO;
    logic         BUSY, READY, DZ;
    logic [W-1:0] HI, LO;

    int n_chk  = 0;
    int n_pass = 0;
    logic [W-1:0] g_hi = '0, g_lo = '0;

    ula_mult_div #(.WIDTH(W)) dut (
        .clock(clock), .reset_n(reset_n), .A(A), .B(B), .OP(OP),
        .START(START), .MTHI(MTHI), .MTLO(MTLO),
        .BUSY(BUSY), .READY(READY), .DZ(DZ), .HI(HI), .LO(LO)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    endtask

    // Reference: MIPS-style results from integer arithmetic
    function automatic void ref_op(input logic [1:0] op, input logic [W-1:0] a, b,
                                   output logic [W-1:0] hi, lo, output logic dz);
        longint sa, sb, q, r;
        logic [63:0] p;
        dz = 1'b0; hi = '0; lo = '0;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            2'd0: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            2'd1: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
            default: begin
                if (b == 0) begin
                    dz = 1'b1; hi = a; lo = '1;
                end else if (op == 2'd2) begin
                    q = sa / sb; r = sa % sb;
                    lo = q[31:0]; hi = r[31:0];
                end else begin
                    lo = a / b; hi = a % b;
                end
            end
        endcase
    endfunction

    // Issue one op (called #1 after a rising edge); disturbs inputs while busy.
    // abort_at > 0 pulls reset that many edges after START and checks the clear.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, b,
                          input string tag, input int abort_at);
        logic [W-1:0] eh, el;
        logic edz;
        int rdy_at, busy_n;
        ref_op(op, a, b, eh, el, edz);
        A = a; B = b; OP = op; START = 1'b1; MTHI = 1'b0; MTLO = 1'b0;
        @(posedge clock); #1;
        START = 1'b0; A = $urandom; B = $urandom;
        rdy_at = -1; busy_n = 0;
        for (int k = 1; k <= 60 && rdy_at < 0; k++) begin
            @(posedge clock); #1;
            if (k == abort_at) begin
                reset_n = 1'b0; START = 1'b0; MTHI = 1'b0; MTLO = 1'b0;
                #1;
                check({tag, ".rst_busy"},  BUSY, 0);
                check({tag, ".rst_ready"}, READY, 0);
                check({tag, ".rst_hi"},    HI, 0);
                check({tag, ".rst_lo"},    LO, 0);
                check({tag, ".rst_dz"},    DZ, 0);
                g_hi = '0; g_lo = '0;
                return;
            end
            if (READY) rdy_at = k;
            else begin
                if (BUSY) busy_n++;
                A = $urandom; B = $urandom; OP = 2'($urandom);
                START = 1'($urandom); MTHI = 1'($urandom); MTLO = 1'($urandom);
            end
        end
        START = 1'b0; MTHI = 1'b0; MTLO = 1'b0;
        check({tag, ".ready_edge"}, rdy_at, LAT);
        check({tag, ".busy_cycles"}, busy_n, LAT - 1);
        check({tag, ".busy_done"}, BUSY, 0);
        check({tag, ".hi"}, HI, eh);
        check({tag, ".lo"}, LO, el);
        check({tag, ".dz"}, DZ, edz);
        g_hi = eh; g_lo = el;
    endtask

    // One idle cycle: READY must be a single pulse and HI/LO must hold
    task automatic gap(input string tag);
        @(posedge clock); #1;
        check({tag, ".ready_pulse"}, READY, 0);
        check({tag, ".hold_hi"}, HI, g_hi);
        check({tag, ".hold_lo"}, LO, g_lo);
    endtask

    task automatic mt(input logic h, input logic l, input logic [W-1:0] v, input string tag);
        A = v; MTHI = h; MTLO = l;
        @(posedge clock); #1;
        MTHI = 1'b0; MTLO = 1'b0;
        if (h) g_hi = v;
        if (l) g_lo = v;
        check({tag, ".hi"}, HI, g_hi);
        check({tag, ".lo"}, LO, g_lo);
        check({tag, ".ready"}, READY, 0);
    endtask

    initial begin
        logic [1:0] rop;
        logic [W-1:0] ra, rb;
        reset_n = 1'b0; A = '0; B = '0; OP = '0; START = 1'b0; MTHI = 1'b0; MTLO = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset.busy", BUSY, 0);
        check("reset.ready", READY, 0);
        check("reset.dz", DZ, 0);
        check("reset.hi", HI, 0);
        check("reset.lo", LO, 0);
        @(negedge clock); reset_n = 1'b1;
        @(posedge clock); #1;

        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 0); gap("multu_max");
        run_op(2'd0, 32'hFFFF_FFFD, 32'd7,         "mult_neg",  0); gap("mult_neg");
        run_op(2'd2, -32'sd7, 32'd2,               "div_neg",   0);
        run_op(2'd3, 32'd100, 32'd7,               "divu",      0); gap("divu");
        run_op(2'd3, 32'h1234, 32'd0,              "divu_dz",   0);
        run_op(2'd1, 32'd2, 32'd3,                 "multu_dzclr", 0);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_wrap",  0);
        run_op(2'd2, -32'sd7, 32'd0,               "div_dz_neg", 0);
        run_op(2'd0, 32'h8000_0000, 32'h8000_0000, "mult_min",  0); gap("mult_min");

        mt(1'b1, 1'b0, 32'hCAFE_0001, "mthi");
        mt(1'b0, 1'b1, 32'hBEEF_0002, "mtlo");
        mt(1'b1, 1'b1, 32'h1357_9BDF, "mthilo");

        run_op(2'd0, 32'd5, -32'sd9,        "abort", 10);
        @(negedge clock); reset_n = 1'b1;
        @(posedge clock); #1;
        run_op(2'd3, 32'd1000, 32'd33,      "post_rst", 0); gap("post_rst");

        for (int i = 0; i < 25; i++) begin
            rop = 2'($urandom);
            ra  = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 20)) : 32'($urandom);
            rb  = ($urandom_range(0, 6) == 0) ? 32'd0 :
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 300)) : 32'($urandom);
            run_op(rop, ra, rb, $sformatf("rnd%0d", i), 0);
            if (i % 3 == 0) gap($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
